m2v_operand_loader: RTL

- Upstream feeder for the systolic matrix-vector multiplier stage.
- Accepts a serial element stream over a valid/ready handshake and assembles four matrix rows plus one vector into parallel operand buses.
- Drives the multiplier's enable for exactly one compute window while holding the operands stable, then pulses done and returns to loading.
- Guarantees the enable gap the multiplier needs to clear its internal counters between runs.

---
 rtl/m2v_operand_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/m2v_operand_loader.sv
// Serial-to-parallel operand loader for the 4x4 systolic matrix-vector multiplier.
// Optional matrix reuse (V-only reloads) is enabled by defining M2V_LOADER_MATRIX_REUSE_EN.
module m2v_operand_loader #(
    parameter int DIMENSION  = 4,
    parameter int WIDTH      = 8,
    parameter int RUN_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
`ifdef M2V_LOADER_MATRIX_REUSE_EN
    input  logic                       reload_m,
`endif
    output logic                       s_ready,
    output logic [DIMENSION*WIDTH-1:0] M1,
    output logic [DIMENSION*WIDTH-1:0] M2,
    output logic [DIMENSION*WIDTH-1:0] M3,
    output logic [DIMENSION*WIDTH-1:0] M4,
    output logic [DIMENSION*WIDTH-1:0] V,
    output logic                       en,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 dbg_state
);

    localparam int BUSW = DIMENSION * WIDTH;
    localparam int CW   = $clog2(RUN_CYCLES + 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      k;
    logic [4:0]      idx;
    logic [2:0]      row;
    logic [1:0]      slot;
    logic [CW-1:0]   cnt;
    logic [BUSW-1:0] bus_q [5];
    logic            ready_q;
    logic            en_q;
    logic            busy_q;
    logic            done_q;

    // Valid/ready: an element moves on a rising edge where s_valid and s_ready
    // are both high; s_ready is a registered decode of LOAD and never looks at s_valid.
    always_comb begin
        idx = k;
`ifdef M2V_LOADER_MATRIX_REUSE_EN
        // A matrix-retaining load starts directly at the first vector slot.
        if (k == 5'd0 && !reload_m) begin
            idx = 5'd16;
        end
`endif
        row  = idx[4:2];
        slot = idx[1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LOAD;
            k       <= 5'd0;
            cnt     <= '0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int r = 0; r < 5; r++) begin
                bus_q[r] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    ready_q <= 1'b1;
                    if (s_valid && ready_q) begin
                        bus_q[row][int'(slot)*WIDTH +: WIDTH] <= s_data;
                        if (idx == 5'd19) begin
                            state   <= RUN;
                            k       <= 5'd0;
                            cnt     <= '0;
                            ready_q <= 1'b0;
                            en_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            k <= idx + 5'd1;
                        end
                    end
                end
                RUN: begin
                    if (cnt == CW'(RUN_CYCLES - 1)) begin
                        state  <= DONE;
                        en_q   <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= LOAD;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= LOAD;
                    en_q    <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = ready_q;
    assign en        = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state;
    assign M1        = bus_q[0];
    assign M2        = bus_q[1];
    assign M3        = bus_q[2];
    assign M4        = bus_q[3];
    assign V         = bus_q[4];

endmodule
